// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with per-frame snapshot and blank guard.
// Optional SEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] data,
  input  logic [3:0]  dp,
  output logic [6:0]  HEX,
  output logic        DP,
  output logic [3:0]  AN,
  output logic        frame_start
);

  localparam int NUM_DIG = 4;
  localparam int CMAX    = (DIV > GUARD) ? DIV : GUARD;
  localparam int CW      = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                    state;
  logic [1:0]                idx;
  logic [CW-1:0]             cnt;
  logic [NUM_DIG-1:0][3:0]   snap;
  logic [NUM_DIG-1:0]        snap_dp;
  logic [NUM_DIG-1:0]        sup;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // A digit goes dark when it and every higher nibble are zero, unless its dp is lit.
  for (genvar g = 0; g < NUM_DIG; g++) begin : g_lz
    if (g == 0) begin : g_d0
      assign sup[g] = 1'b0;
    end else begin : g_dn
      assign sup[g] = !snap_dp[g] && (snap[NUM_DIG-1:g] == '0);
    end
  end
`else
  assign sup = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BLANK;
      idx         <= '0;
      cnt         <= '0;
      snap        <= '0;
      snap_dp     <= '0;
      HEX         <= 7'h7F;
      DP          <= 1'b1;
      AN          <= 4'b1111;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      HEX         <= 7'h7F;
      DP          <= 1'b1;
      AN          <= 4'b1111;
      if (!en) begin
        state <= IDLE;
        idx   <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= BLANK;
            idx   <= '0;
            cnt   <= '0;
          end
          BLANK: begin
            // First guard clock of digit0 latches the whole frame to avoid tearing.
            if (idx == 2'd0 && cnt == '0) begin
              snap        <= data;
              snap_dp     <= dp;
              frame_start <= 1'b1;
            end
            if (cnt == CW'(GUARD - 1)) begin
              state <= SHOW;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SHOW: begin
            if (!sup[idx]) begin
              AN  <= ~(4'b0001 << idx);
              HEX <= seg7(snap[idx]);
              DP  <= ~snap_dp[idx];
            end
            if (cnt == CW'(DIV - 1)) begin
              state <= BLANK;
              idx   <= idx + 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
